// File: rtl/demorgan_sweep.sv
// -----------------------------------------------------------------------------
// demorgan_sweep
//   Self-test sequencer for a De Morgan gate stage. On request it walks the two
//   stage inputs A/B through 00, 01, 10, 11. It holds each combination for
//   SETTLE cycles, then spends one CHECK cycle comparing the eight stage outputs
//   against their ideal values. Results are held once the sweep completes.
//
// Parameters
//   SETTLE        cycles each combination is held before sampling (1..15)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   start         sweep request, honoured only in IDLE or DONE
//   a_out, b_out  drive the gate stage inputs A, B (registered)
//   nA .. nAorB   gate stage outputs under test
//   busy          sweep in progress (DRIVE or CHECK)
//   done          results of the last completed sweep are being held
//   pass          last sweep found no failing combination (valid in DONE)
//   err_count     number of failing combinations, 0..4
//   fail_vector   bit i set when combination i failed
// -----------------------------------------------------------------------------
module demorgan_sweep #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       nA,
    input  logic       nB,
    input  logic       nAandnB,
    input  logic       nAornB,
    input  logic       AandB,
    input  logic       nAandB,
    input  logic       AorB,
    input  logic       nAorB,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vector
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter value on the last DRIVE cycle of a combination.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    // Ideal gate stage response, ordered like observed_s below.
    function automatic logic [7:0] gate_ref(input logic a, input logic b);
        gate_ref = {~a, ~b, ~a & ~b, ~a | ~b, a & b, ~(a & b), a | b, ~(a | b)};
    endfunction

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic [7:0] observed_s;
    logic       mismatch_s;

    assign observed_s = {nA, nB, nAandnB, nAornB, AandB, nAandB, AorB, nAorB};
    // Any single wrong output condemns the whole combination.
    assign mismatch_s = (observed_s != gate_ref(idx_q[1], idx_q[0]));

    // Next-state and next-output logic; everything holds unless changed below.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    err_d   = 3'd0;
                    fail_d  = 4'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end else begin
                    state_d = DRIVE;
                end
            end
            CHECK: begin
                if (mismatch_s) begin
                    fail_d = fail_q | (4'b0001 << idx_q);
                    err_d  = err_q + 3'd1;
                end else begin
                    fail_d = fail_q;
                end
                if (idx_q != 2'd3) begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = 4'd0;
                    a_d     = idx_d[1];
                    b_d     = idx_d[0];
                end else begin
                    // Last combination: idx stays at 3 so A/B remain 1/1.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 3'd0);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign a_out       = a_q;
    assign b_out       = b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
    assign fail_vector = fail_q;

endmodule

// File: doc/demorgan_sweep.md
DEMORGAN_SWEEP -- requirements
Module: demorgan_sweep

Interface
REQ-001 Parameter: SETTLE, default 2, number of cycles each input combination is held before outputs are sampled; legal range 1..15.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request one sweep; sampled only in IDLE or DONE.
REQ-005 Port: a_out, b_out  output  1 each  drive the De Morgan gate stage inputs A, B.
REQ-006 Port: nA, nB, nAandnB, nAornB, AandB, nAandB, AorB, nAorB  input  1 each  gate stage outputs under test.
REQ-007 Port: busy  output  1  high while a sweep is in progress.
REQ-008 Port: done  output  1  high while results of the last completed sweep are held.
REQ-009 Port: pass  output  1  high in DONE when err_count == 0.
REQ-010 Port: err_count  output  3  number of failing input combinations, 0..4.
REQ-011 Port: fail_vector  output  4  bit i set when combination i failed.

Function
REQ-012 FSM states: IDLE, DRIVE, CHECK, DONE.
REQ-013 Combination index idx (2 bits): a_out = idx[1], b_out = idx[0], registered, changing only on a transition into DRIVE.
REQ-014 IDLE or DONE with start=1: next state DRIVE, idx=0, settle counter=0, err_count=0, fail_vector=0, done=0, pass=0.
REQ-015 IDLE or DONE with start=0: state and all outputs hold.
REQ-016 DRIVE: settle counter increments each cycle; after SETTLE cycles in DRIVE, next state CHECK.
REQ-017 CHECK (exactly one cycle): compare inputs against A=idx[1], B=idx[0]: nA=~A, nB=~B, nAandnB=~A&~B, nAornB=~A|~B, AandB=A&B, nAandB=~(A&B), AorB=A|B, nAorB=~(A|B).
REQ-018 Any of the 8 mismatching in CHECK: set fail_vector[idx], increment err_count by 1 (once per combination regardless of mismatch count).
REQ-019 CHECK with idx<3: next state DRIVE, idx+1, settle counter cleared.
REQ-020 CHECK with idx=3: next state DONE; idx does not wrap; a_out/b_out stay 1/1.
REQ-021 busy = 1 in DRIVE and CHECK, 0 otherwise; done = 1 only in DONE.
REQ-022 pass = (err_count == 0) registered on the DONE entry edge; 0 in every other state.
REQ-023 Sweep length: exactly 4*(SETTLE+1) rising edges from the edge sampling start to the edge entering DONE.
REQ-024 start during DRIVE or CHECK: ignored, no restart, no effect on results.
REQ-025 start held high continuously: one cycle in DONE, then a new sweep begins on the next edge.
REQ-026 Inputs sampled only in CHECK; input changes during DRIVE have no effect.

Reset
REQ-027 reset=1 at a rising edge overrides all other conditions: state IDLE, idx=0, settle counter=0.
REQ-028 Reset values: a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_vector=0.
REQ-029 Reset mid-sweep: abandon the sweep, partial results discarded; start in the first cycle after reset release is accepted.

Verification
REQ-030 Correct gate stage attached, SETTLE=2, start pulsed 1 cycle -> a_out/b_out step 00,01,10,11, each held 3 cycles; done rises 12 edges after the start edge; pass=1, err_count=0, fail_vector=0000.
REQ-031 nAorB stuck at 0 -> fails only combination 0 -> fail_vector=0001, err_count=1, pass=0.
REQ-032 AandB forced to ~(A&B), nA stuck at 1 -> all four combinations fail -> fail_vector=1111, err_count=4, pass=0.
REQ-033 reset asserted during CHECK of idx=2 after a failure on idx=1 -> next cycle all outputs at reset values; new sweep with correct stage ends with pass=1, fail_vector=0000.
REQ-034 start pulsed during DRIVE of idx=1, then start held high through DONE -> first sweep completes unchanged at 12 edges; DONE lasts 1 cycle; second sweep begins with err_count and fail_vector cleared.
REQ-035 SETTLE=1 -> each combination held 2 cycles; done after 8 edges.
